// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table in binary angle, gain-compensation constant, FSM states.
package cordic_pkg;

    localparam int unsigned GAIN_Q15   = 19898;
    localparam int unsigned GAIN_SHIFT = 15;

    typedef enum logic [2:0] {
        StIdle,
        StFold,
        StIter,
        StOut,
        StOutScale
    } cordic_state_e;

    // atan(2^-k) as a fraction of a full turn, scaled to 2^32.
    function automatic logic [31:0] atan_turns32(input int unsigned k);
        case (k)
            0:       return 32'h2000_0000;
            1:       return 32'h12E4_051E;
            2:       return 32'h09FB_385B;
            3:       return 32'h0511_11D4;
            4:       return 32'h028B_0D43;
            5:       return 32'h0145_D7E1;
            6:       return 32'h00A2_F61E;
            7:       return 32'h0051_7C55;
            8:       return 32'h0028_BE53;
            9:       return 32'h0014_5F2F;
            10:      return 32'h000A_2F98;
            11:      return 32'h0005_17CC;
            12:      return 32'h0002_8BE6;
            13:      return 32'h0001_45F3;
            14:      return 32'h0000_A2FA;
            15:      return 32'h0000_517D;
            // Small-angle region: atan(2^-k) ~= 2^-k rad.
            default: return 32'd683565276 >> k;
        endcase
    endfunction

    // Round the 32-bit turn fraction down to a pw-bit binary angle.
    function automatic logic [31:0] atan_angle(input int unsigned k, input int unsigned pw);
        logic [32:0] full;
        full = {1'b0, atan_turns32(k)};
        if (pw >= 32) begin
            return full[31:0];
        end
        full = full + (33'd1 << (31 - pw));
        return 32'(full >> (32 - pw));
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: atan(2^-k) as a PHASE_WIDTH-bit binary angle.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = 16,
    parameter int unsigned K_WIDTH     = 4
) (
    input  logic [K_WIDTH-1:0]     k,
    output logic [PHASE_WIDTH-1:0] angle
);

    always_comb begin
        angle = PHASE_WIDTH'(atan_angle(32'(k), PHASE_WIDTH));
    end

endmodule

// File: rtl/cordic_vector.sv
// Iterative CORDIC vectoring engine: I/Q sample in, magnitude and binary-angle phase out.
// Define CORDIC_GAIN_COMP_EN to scale the magnitude by 1/K (adds one cycle of latency).
module cordic_vector
    import cordic_pkg::*;
#(
    parameter int unsigned I_WIDTH     = 16,
    parameter int unsigned PHASE_WIDTH = 16,
    parameter int unsigned ITERATIONS  = 14
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic                      i_valid,
    input  logic signed [I_WIDTH-1:0] i_i,
    input  logic signed [I_WIDTH-1:0] i_q,
    output logic [I_WIDTH+1:0]        o_mag,
    output logic [PHASE_WIDTH-1:0]    o_phase,
    output logic                      o_valid,
    output logic                      o_busy,
    output logic                      o_overrun
);

    localparam int unsigned W       = I_WIDTH + 2;
    localparam int unsigned K_WIDTH = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam logic [K_WIDTH-1:0]     K_LAST    = K_WIDTH'(ITERATIONS - 1);
    localparam logic [PHASE_WIDTH-1:0] HALF_TURN = {1'b1, {(PHASE_WIDTH - 1){1'b0}}};

    cordic_state_e          state_q;
    logic signed [W-1:0]    x_q;
    logic signed [W-1:0]    y_q;
    logic [PHASE_WIDTH-1:0] z_q;
    logic [K_WIDTH-1:0]     k_q;
    logic                   zero_q;

    logic [PHASE_WIDTH-1:0] atan_k;
    logic signed [W-1:0]    x_sh;
    logic signed [W-1:0]    y_sh;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int unsigned PROD_W = W + GAIN_SHIFT;
    localparam logic [PROD_W-1:0] GAIN = PROD_W'(GAIN_Q15);
    logic [PROD_W-1:0] prod_q;
`endif

    cordic_atan_rom #(
        .PHASE_WIDTH(PHASE_WIDTH),
        .K_WIDTH    (K_WIDTH)
    ) u_atan_rom (
        .k    (k_q),
        .angle(atan_k)
    );

    assign x_sh = x_q >>> k_q;
    assign y_sh = y_q >>> k_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StIdle;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            k_q       <= '0;
            zero_q    <= 1'b0;
            o_mag     <= '0;
            o_phase   <= '0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_overrun <= 1'b0;
`ifdef CORDIC_GAIN_COMP_EN
            prod_q    <= '0;
`endif
        end else if (i_en) begin
            o_valid   <= 1'b0;
            // Samples arriving mid-conversion are dropped, only flagged.
            o_overrun <= i_valid && (state_q != StIdle);
            case (state_q)
                StIdle: begin
                    if (i_valid) begin
                        x_q     <= W'(i_i);
                        y_q     <= W'(i_q);
                        o_busy  <= 1'b1;
                        state_q <= StFold;
                    end
                end
                StFold: begin
                    // Rotate left-half-plane vectors by 180 deg into CORDIC convergence range.
                    if (x_q[W-1]) begin
                        x_q <= -x_q;
                        y_q <= -y_q;
                        z_q <= HALF_TURN;
                    end else begin
                        z_q <= '0;
                    end
                    zero_q  <= (x_q == '0) && (y_q == '0);
                    k_q     <= '0;
                    state_q <= StIter;
                end
                StIter: begin
                    if (!y_q[W-1]) begin
                        x_q <= x_q + y_sh;
                        y_q <= y_q - x_sh;
                        z_q <= z_q + atan_k;
                    end else begin
                        x_q <= x_q - y_sh;
                        y_q <= y_q + x_sh;
                        z_q <= z_q - atan_k;
                    end
                    k_q <= k_q + K_WIDTH'(1);
                    if (k_q == K_LAST) begin
                        state_q <= StOut;
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                StOut: begin
                    prod_q  <= GAIN * {{GAIN_SHIFT{1'b0}}, x_q};
                    state_q <= StOutScale;
                end
                StOutScale: begin
                    o_mag   <= zero_q ? '0 : prod_q[PROD_W-1:GAIN_SHIFT];
                    o_phase <= zero_q ? '0 : z_q;
                    o_valid <= 1'b1;
                    o_busy  <= 1'b0;
                    state_q <= StIdle;
                end
`else
                StOut: begin
                    o_mag   <= zero_q ? '0 : $unsigned(x_q);
                    o_phase <= zero_q ? '0 : z_q;
                    o_valid <= 1'b1;
                    o_busy  <= 1'b0;
                    state_q <= StIdle;
                end
`endif
                default: begin
                    o_busy  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vector.sv
// Self-checking bench for cordic_vector: vector table through a scoreboard plus overrun,
// reset-abort and clock-enable sequences. Honours CORDIC_GAIN_COMP_EN.
`timescale 1ns/1ps
module tb_cordic_vector;

    localparam int ITERATIONS = 14;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT    = ITERATIONS + 3;
    localparam int MAG_R  = 16384;
    localparam int MAG_R2 = 23170;
    localparam int MAG_FS = 46341;
    localparam int MAG_H  = 32768;
    localparam int MAG_FA = 46340;
`else
    localparam int LAT    = ITERATIONS + 2;
    localparam int MAG_R  = 26981;
    localparam int MAG_R2 = 38155;
    localparam int MAG_FS = 76312;
    localparam int MAG_H  = 53961;
    localparam int MAG_FA = 76311;
`endif

    logic               i_clk   = 1'b0;
    logic               i_rst   = 1'b1;
    logic               i_en    = 1'b1;
    logic               i_valid = 1'b0;
    logic signed [15:0] i_i     = '0;
    logic signed [15:0] i_q     = '0;
    logic [17:0]        o_mag;
    logic [15:0]        o_phase;
    logic               o_valid;
    logic               o_busy;
    logic               o_overrun;

    typedef struct {
        int i;
        int q;
        int mag;
        int mtol;
        int ph;
        int ptol;
    } vec_t;

    typedef struct {
        int id;
        int mag;
        int mtol;
        int ph;
        int ptol;
        int accept_cyc;
        int extra;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[10];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   ovr_cnt = 0;

    cordic_vector #(
        .I_WIDTH    (16),
        .PHASE_WIDTH(16),
        .ITERATIONS (ITERATIONS)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (i_en),
        .i_valid  (i_valid),
        .i_i      (i_i),
        .i_q      (i_q),
        .o_mag    (o_mag),
        .o_phase  (o_phase),
        .o_valid  (o_valid),
        .o_busy   (o_busy),
        .o_overrun(o_overrun)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check_val(input string name, input longint act, input longint exp,
                             input longint tol);
        checks++;
        if (act < exp - tol || act > exp + tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (+-%0d)", name, act, exp, tol);
        end
    endtask

    task automatic check_phase(input string name, input logic [15:0] act,
                               input logic [15:0] exp, input int tol);
        int d;
        d = int'($signed(16'(act - exp)));
        checks++;
        if (d > tol || d < -tol) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h (+-%0d)", name, act, exp, tol);
        end
    endtask

    // Monitor samples 1 ns after the edge; stimulus acts 2 ns after it.
    always @(posedge i_clk) begin
        exp_t e;
        #1;
        if (o_overrun) ovr_cnt++;
        if (o_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: o_valid with nothing pending (mag=%0d phase=0x%h)",
                         o_mag, o_phase);
            end else begin
                e = sb.pop_front();
                check_val($sformatf("v%0d_mag", e.id), longint'(o_mag), e.mag, e.mtol);
                check_phase($sformatf("v%0d_phase", e.id), o_phase, 16'(e.ph), e.ptol);
                check_val($sformatf("v%0d_latency", e.id), cyc - e.accept_cyc,
                          LAT + e.extra, 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #2;
        end
    endtask

    task automatic send(input vec_t v, input int id, input int extra, input bit accept);
        exp_t e;
        i_valid = 1'b1;
        i_i     = 16'(v.i);
        i_q     = 16'(v.q);
        if (accept) begin
            e.id         = id;
            e.mag        = v.mag;
            e.mtol       = v.mtol;
            e.ph         = v.ph;
            e.ptol       = v.ptol;
            e.accept_cyc = cyc + 1;
            e.extra      = extra;
            sb.push_back(e);
        end
        tick(1);
        i_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check_val("drain_pending", sb.size(), 0, 0);
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_mag"}, longint'(o_mag), 0, 0);
        check_val({tag, "_phase"}, longint'(o_phase), 0, 0);
        check_val({tag, "_valid"}, longint'(o_valid), 0, 0);
        check_val({tag, "_busy"}, longint'(o_busy), 0, 0);
        check_val({tag, "_overrun"}, longint'(o_overrun), 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int ovr_base;
        vec_t v;

        tbl[0] = '{ 16384,      0, MAG_R,  4, 'h0000, 2};
        tbl[1] = '{     0,  16384, MAG_R,  6, 'h4000, 2};
        tbl[2] = '{-16384,      0, MAG_R,  6, 'h8000, 2};
        tbl[3] = '{-16384, -16384, MAG_R2, 6, 'hA000, 2};
        tbl[4] = '{-32768, -32768, MAG_FS, 8, 'hA000, 2};
        tbl[5] = '{     0,      0, 0,      0, 'h0000, 0};
        tbl[6] = '{     0, -16384, MAG_R,  6, 'hC000, 2};
        tbl[7] = '{ 16384,  16384, MAG_R2, 6, 'h2000, 2};
        tbl[8] = '{-32768,      0, MAG_H,  8, 'h8000, 2};
        tbl[9] = '{ 32767, -32768, MAG_FA, 8, 'hE000, 2};

        tick(3);
        check_reset_outputs("reset");
        i_rst = 1'b0;
        tick(2);

        // Back-to-back: each sample issued the cycle after the previous OUT.
        for (int n = 0; n < 10; n++) begin
            send(tbl[n], n, 0, 1'b1);
            check_val($sformatf("v%0d_busy", n), longint'(o_busy), 1, 0);
            drain(LAT + 10);
            check_val($sformatf("v%0d_idle", n), longint'(o_busy), 0, 0);
        end

        // Overrun: second sample five cycles after the first is dropped.
        ovr_base = ovr_cnt;
        send(tbl[0], 10, 0, 1'b1);
        tick(4);
        send(tbl[3], 99, 0, 1'b0);
        drain(LAT + 10);
        tick(LAT + 4);
        check_val("overrun_pulses", ovr_cnt - ovr_base, 1, 0);

        // Reset during cycle 8 of a conversion aborts it.
        send(tbl[0], 11, 0, 1'b1);
        tick(7);
        i_rst = 1'b1;
        sb.delete();
        #1;
        check_reset_outputs("abort");
        tick(2);
        i_rst = 1'b0;
        tick(LAT + 4);
        check_val("abort_no_valid_mag", longint'(o_mag), 0, 0);
        send(tbl[3], 12, 0, 1'b1);
        drain(LAT + 10);

        // Clock enable low for six cycles stretches the conversion by six.
        send(tbl[1], 13, 6, 1'b1);
        tick(4);
        i_en = 1'b0;
        tick(6);
        check_val("freeze_busy", longint'(o_busy), 1, 0);
        i_en = 1'b1;
        drain(LAT + 20);

        tick(2);
        check_val("overrun_total", ovr_cnt, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
